grid_world_env: RTL and testbench
=================================

// Module: grid_world_env
// PURPOSE
//  Environment side of the Q-learning loop: accepts an action from the agent/policy generator,
//  moves the agent on a GRID_W x GRID_H grid, returns next_state and signed next_reward.
//  Also tracks episode steps and restarts episodes on goal or timeout.
//  Sits opposite the agent: its next_state/next_reward outputs feed the agent's inputs.
// PARAMETERS
//  GRID_W        8        grid columns; state = row*GRID_W + col
//  GRID_H        8        grid rows; GRID_W*GRID_H <= 64
//  START_STATE   0        state loaded at reset and at every episode restart
//  GOAL_STATE    63       terminal state
//  GOAL_REWARD   16'sd100 reward on entering GOAL_STATE
//  STEP_REWARD   -16'sd1  reward for a legal non-goal move
//  WALL_REWARD   -16'sd10 reward for a move blocked by the grid edge (or obstacle); state unchanged
//  MAX_STEPS     255      steps per episode before timeout, 1..255
//  OBSTACLE_MASK 64'h0    bit s = 1 marks state s blocked (used only with GRID_OBSTACLE_EN)
// PORTS
//  clk           in   1   clock, all logic on rising edge
//  rst_n         in   1   synchronous active-low reset
//  en            in   1   global enable; 0 freezes all state, action ignored
//  action_valid  in   1   action is valid this cycle
//  action        in   2   0=up(row-1) 1=right(col+1) 2=down(row+1) 3=left(col-1)
//  action_ready  out  1   environment can accept an action this cycle
//  next_state    out  6   current agent position after the last step
//  next_reward   out  16  signed two's-complement reward of the last step
//  state_valid   out  1   1-cycle pulse: next_state/next_reward updated
//  episode_done  out  1   1-cycle pulse with state_valid on goal or timeout step
//  step_count    out  8   steps taken in the current episode
//  episode_count out  16  completed episodes, wraps 65535 -> 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): FSM=RUN, next_state=START_STATE, next_reward=0, step_count=0,
//   episode_count=0, state_valid=0, episode_done=0, action_ready=1. Reset overrides en.
//  FSM states: RUN (action_ready=1), RESTART (action_ready=0). Handshake: step taken when
//   en & action_valid & action_ready at clk edge; outputs update at that edge (1-cycle latency).
//  Move: compute row/col; edge-exceeding move -> state unchanged, WALL_REWARD.
//   Legal move to GOAL_STATE -> GOAL_REWARD; else STEP_REWARD. step_count += 1.
//  Episode end: goal reached OR step_count reaches MAX_STEPS on this step (timeout; reward as
//   computed for the move). Then episode_done=1, episode_count += 1, FSM -> RESTART.
//   Goal and timeout on the same step count as one episode end.
//  RESTART (one cycle, if en=1): next_state=START_STATE, next_reward=0, step_count=0,
//   state_valid=1, episode_done=0, FSM -> RUN. With en=0, stays in RESTART.
//  state_valid/episode_done are 0 in all cycles without a step or restart.
//  action_valid while action_ready=0 or en=0: dropped, no state change (agent must re-present).
//  Reset mid-episode: immediate return to reset values; no episode_done pulse.
// CONFIGURATION
//  GRID_OBSTACLE_EN defined: a move whose target has OBSTACLE_MASK bit set is treated as a wall
//   (state unchanged, WALL_REWARD, counts as a step). START/GOAL bits in the mask are ignored.
//  Not defined: OBSTACLE_MASK unused; only grid edges block moves.
// TESTING
//  Reset, then action=1 x1 -> next_state=1, next_reward=-1, state_valid pulse, step_count=1.
//  From state 0, action=0 (up) -> next_state=0, next_reward=-10 (0xFFF6), step_count=1.
//  Drive 7x right then 7x down -> 14th step next_state=63, reward=100, episode_done=1,
//   episode_count=1; next cycle next_state=0, reward=0, step_count=0, action_ready=0 then 1.
//  MAX_STEPS=4, action=3 repeatedly from 0 -> 4th step episode_done=1, episode_count=1,
//   restart to state 0.
//  en=0 with action_valid=1 for 5 cycles -> no output change; rst_n=0 at state 9 -> state 0, counts 0.
//  GRID_OBSTACLE_EN, OBSTACLE_MASK=64'h2: from 0, action=1 -> state 0, reward -10; without macro -> state 1.

Source files
------------

// File: rtl/grid_world_env.sv
// Grid-world environment for a Q-learning loop: applies agent actions on a GRID_W x GRID_H grid,
// returns next state / signed reward, and restarts episodes on goal or timeout. Optional macro: GRID_OBSTACLE_EN.
module grid_world_env #(
  parameter int                 GRID_W        = 8,
  parameter int                 GRID_H        = 8,
  parameter int                 START_STATE   = 0,
  parameter int                 GOAL_STATE    = 63,
  parameter logic signed [15:0] GOAL_REWARD   = 16'sd100,
  parameter logic signed [15:0] STEP_REWARD   = -16'sd1,
  parameter logic signed [15:0] WALL_REWARD   = -16'sd10,
  parameter int                 MAX_STEPS     = 255,
  parameter logic [63:0]        OBSTACLE_MASK = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               action_valid,
  input  logic [1:0]         action,
  output logic               action_ready,
  output logic [5:0]         next_state,
  output logic signed [15:0] next_reward,
  output logic               state_valid,
  output logic               episode_done,
  output logic [7:0]         step_count,
  output logic [15:0]        episode_count
);

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_DOWN  = 2'd2,
    ACT_LEFT  = 2'd3
  } action_e;

  typedef enum logic {
    RUN     = 1'b0,
    RESTART = 1'b1
  } fsm_e;

  localparam logic [5:0] COLS     = 6'(GRID_W);
  localparam logic [5:0] LAST_COL = 6'(GRID_W - 1);
  localparam logic [5:0] LAST_ROW = 6'(GRID_H - 1);
  localparam logic [5:0] START    = 6'(START_STATE);
  localparam logic [5:0] GOAL     = 6'(GOAL_STATE);
  localparam logic [7:0] MAX_CNT  = 8'(MAX_STEPS);

  fsm_e               fsm_q, fsm_d;
  logic [5:0]         pos_q, pos_d;
  logic signed [15:0] reward_q, reward_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [7:0]         steps_q, steps_d;
  logic [15:0]        episodes_q, episodes_d;

  logic [5:0] row, col, target;
  logic       edge_block, obstacle_hit, wall, goal_hit, timeout, take_step;

  // Move datapath: candidate target square and whether the move is blocked.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    row        = pos_q / COLS;
    col        = pos_q % COLS;
    edge_block = 1'b0;
    target     = pos_q;
    unique case (action_e'(action))
      ACT_UP: begin
        edge_block = (row == '0);
        target     = pos_q - COLS;
      end
      ACT_RIGHT: begin
        edge_block = (col == LAST_COL);
        target     = pos_q + 6'd1;
      end
      ACT_DOWN: begin
        edge_block = (row == LAST_ROW);
        target     = pos_q + COLS;
      end
      ACT_LEFT: begin
        edge_block = (col == '0);
        target     = pos_q - 6'd1;
      end
      default: ;
    endcase
  end

`ifdef GRID_OBSTACLE_EN
  // Start and goal squares can never be obstacles, whatever the mask says.
  assign obstacle_hit = !edge_block && OBSTACLE_MASK[target] &&
                        (target != START) && (target != GOAL);
`else
  logic unused_obstacle_mask;
  assign unused_obstacle_mask = ^OBSTACLE_MASK;
  assign obstacle_hit         = 1'b0;
`endif

  assign wall      = edge_block || obstacle_hit;
  assign goal_hit  = !wall && (target == GOAL);
  assign timeout   = (steps_q + 8'd1) == MAX_CNT;
  assign take_step = en && action_valid && (fsm_q == RUN);

  always_comb begin
    fsm_d      = fsm_q;
    pos_d      = pos_q;
    reward_d   = reward_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    steps_d    = steps_q;
    episodes_d = episodes_q;
    unique case (fsm_q)
      RUN: begin
        if (take_step) begin
          valid_d = 1'b1;
          steps_d = steps_q + 8'd1;
          if (wall) begin
            reward_d = WALL_REWARD;
          end else begin
            pos_d    = target;
            reward_d = goal_hit ? GOAL_REWARD : STEP_REWARD;
          end
          // Goal and timeout on the same step close a single episode.
          if (goal_hit || timeout) begin
            done_d     = 1'b1;
            episodes_d = episodes_q + 16'd1;
            fsm_d      = RESTART;
          end
        end
      end
      RESTART: begin
        if (en) begin
          pos_d    = START;
          reward_d = '0;
          steps_d  = '0;
          valid_d  = 1'b1;
          fsm_d    = RUN;
        end
      end
      default: fsm_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= RUN;
      pos_q      <= START;
      reward_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      steps_q    <= '0;
      episodes_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      pos_q      <= pos_d;
      reward_q   <= reward_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      steps_q    <= steps_d;
      episodes_q <= episodes_d;
    end
  end

  assign action_ready  = (fsm_q == RUN);
  assign next_state    = pos_q;
  assign next_reward   = reward_q;
  assign state_valid   = valid_q;
  assign episode_done  = done_q;
  assign step_count    = steps_q;
  assign episode_count = episodes_q;

endmodule

// File: tb/tb_grid_world_env.sv
// Self-checking bench for grid_world_env: directed scenarios plus randomized traffic
// compared against a row/column reference model, on a default instance and a MAX_STEPS=4 instance.
module tb_grid_world_env;

  typedef struct packed {
    logic        ready;
    logic [5:0]  st;
    logic [15:0] rw;
    logic        sv;
    logic        ed;
    logic [7:0]  sc;
    logic [15:0] ec;
  } obs_t;

  localparam obs_t RST_OBS = {1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 8'd0, 16'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       action_valid = 1'b0;
  logic [1:0] action = 2'd0;

  logic        a_ready, a_sv, a_ed, b_ready, b_sv, b_ed;
  logic [5:0]  a_st, b_st;
  logic [15:0] a_rw, b_rw, a_ec, b_ec;
  logic [7:0]  a_sc, b_sc;
  obs_t        obs_a, obs_b, exp_a, exp_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  grid_world_env dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .action_valid(action_valid), .action(action),
    .action_ready(a_ready), .next_state(a_st), .next_reward(a_rw), .state_valid(a_sv),
    .episode_done(a_ed), .step_count(a_sc), .episode_count(a_ec)
  );

  grid_world_env #(.MAX_STEPS(4), .OBSTACLE_MASK(64'h2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .action_valid(action_valid), .action(action),
    .action_ready(b_ready), .next_state(b_st), .next_reward(b_rw), .state_valid(b_sv),
    .episode_done(b_ed), .step_count(b_sc), .episode_count(b_ec)
  );

  assign obs_a = {a_ready, a_st, a_rw, a_sv, a_ed, a_sc, a_ec};
  assign obs_b = {b_ready, b_st, b_rw, b_sv, b_ed, b_sc, b_ec};

  // Reference model: walks an 8x8 grid using signed row/column coordinates.
  function automatic obs_t model(input obs_t m, input bit rst, input bit e, input bit v,
                                 input int act, input int max_steps, input logic [63:0] mask);
    obs_t n;
    int   r, c, tgt;
    bit   blocked;
    n    = m;
    n.sv = 1'b0;
    n.ed = 1'b0;
    if (rst) return RST_OBS;
    if (!e) return n;
    if (!m.ready) begin
      n.ready = 1'b1;
      n.st    = 6'd0;
      n.rw    = 16'd0;
      n.sc    = 8'd0;
      n.sv    = 1'b1;
      return n;
    end
    if (!v) return n;
    r = int'(m.st) / 8;
    c = int'(m.st) % 8;
    case (act)
      0: r = r - 1;
      1: c = c + 1;
      2: r = r + 1;
      default: c = c - 1;
    endcase
    blocked = (r < 0) || (r > 7) || (c < 0) || (c > 7);
    tgt     = r * 8 + c;
`ifdef GRID_OBSTACLE_EN
    if (!blocked && mask[tgt] && tgt != 0 && tgt != 63) blocked = 1'b1;
`else
    if (mask == 64'hFFFF_FFFF_FFFF_FFFF) blocked = blocked;
`endif
    n.sv = 1'b1;
    n.sc = m.sc + 8'd1;
    if (blocked) begin
      n.rw = 16'hFFF6;
    end else begin
      n.st = 6'(tgt);
      n.rw = (tgt == 63) ? 16'd100 : 16'hFFFF;
    end
    if ((!blocked && tgt == 63) || int'(n.sc) == max_steps) begin
      n.ed    = 1'b1;
      n.ec    = m.ec + 16'd1;
      n.ready = 1'b0;
    end
    return n;
  endfunction

  // Drives one clock of stimulus, advances both models, and settles for sampling.
  task automatic cycle(input bit rst, input bit e, input bit v, input logic [1:0] a);
    rst_n        = !rst;
    en           = e;
    action_valid = v;
    action       = a;
    @(posedge clk);
    exp_a = model(exp_a, rst, e, v, int'(a), 255, 64'h0);
    exp_b = model(exp_b, rst, e, v, int'(a), 4, 64'h2);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 2'd1);
    cycle(1, 0, 0, 2'd0);
    n_total++;
    if (obs_a !== RST_OBS) $display("FAIL reset_a: got %h expected %h", obs_a, RST_OBS);
    else n_pass++;
    n_total++;
    if (obs_b !== RST_OBS) $display("FAIL reset_b: got %h expected %h", obs_b, RST_OBS);
    else n_pass++;
  endtask

  task automatic test_single_right();
    cycle(1, 1, 0, 2'd0);
    cycle(0, 1, 1, 2'd1);
    n_total++;
    if ({a_st, a_rw, a_sv, a_ed, a_sc} !== {6'd1, 16'hFFFF, 1'b1, 1'b0, 8'd1})
      $display("FAIL single_right: got st=%0d rw=%h sv=%b ed=%b sc=%0d expected st=1 rw=ffff sv=1 ed=0 sc=1",
               a_st, a_rw, a_sv, a_ed, a_sc);
    else n_pass++;
    cycle(0, 1, 0, 2'd0);
    n_total++;
    if ({a_sv, a_st} !== {1'b0, 6'd1})
      $display("FAIL pulse_clear: got sv=%b st=%0d expected sv=0 st=1", a_sv, a_st);
    else n_pass++;
  endtask

  task automatic test_wall();
    cycle(1, 1, 0, 2'd0);
    cycle(0, 1, 1, 2'd0);
    n_total++;
    if ({a_st, a_rw, a_sv, a_sc} !== {6'd0, 16'hFFF6, 1'b1, 8'd1})
      $display("FAIL wall_up: got st=%0d rw=%h sv=%b sc=%0d expected st=0 rw=fff6 sv=1 sc=1",
               a_st, a_rw, a_sv, a_sc);
    else n_pass++;
  endtask

  task automatic test_obstacle();
    logic [21:0] want;
`ifdef GRID_OBSTACLE_EN
    want = {6'd0, 16'hFFF6};
`else
    want = {6'd1, 16'hFFFF};
`endif
    cycle(1, 1, 0, 2'd0);
    cycle(0, 1, 1, 2'd1);
    n_total++;
    if ({b_st, b_rw} !== want)
      $display("FAIL obstacle: got st=%0d rw=%h expected st=%0d rw=%h", b_st, b_rw, want[21:16], want[15:0]);
    else n_pass++;
  endtask

  task automatic test_goal();
    bit early_done = 1'b0;
    cycle(1, 1, 0, 2'd0);
    for (int i = 0; i < 14; i++) begin
      cycle(0, 1, 1, (i < 7) ? 2'd1 : 2'd2);
      if (i < 13) early_done |= a_ed;
    end
    n_total++;
    if (early_done) $display("FAIL goal_early_done: got 1 expected 0");
    else n_pass++;
    n_total++;
    if ({a_st, a_rw, a_sv, a_ed, a_ec, a_ready} !== {6'd63, 16'd100, 1'b1, 1'b1, 16'd1, 1'b0})
      $display("FAIL goal_step: got st=%0d rw=%h sv=%b ed=%b ec=%0d rdy=%b expected st=63 rw=0064 sv=1 ed=1 ec=1 rdy=0",
               a_st, a_rw, a_sv, a_ed, a_ec, a_ready);
    else n_pass++;
    cycle(0, 1, 1, 2'd1);
    n_total++;
    if ({a_st, a_rw, a_sc, a_sv, a_ed, a_ready} !== {6'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b1})
      $display("FAIL goal_restart: got st=%0d rw=%h sc=%0d sv=%b ed=%b rdy=%b expected st=0 rw=0000 sc=0 sv=1 ed=0 rdy=1",
               a_st, a_rw, a_sc, a_sv, a_ed, a_ready);
    else n_pass++;
    cycle(0, 1, 1, 2'd1);
    n_total++;
    if ({a_st, a_sc, a_ec} !== {6'd1, 8'd1, 16'd1})
      $display("FAIL goal_next_episode: got st=%0d sc=%0d ec=%0d expected st=1 sc=1 ec=1", a_st, a_sc, a_ec);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 2'd2);
    n_total++;
    if (a_st !== 6'd9) $display("FAIL mid_reach9: got st=%0d expected 9", a_st);
    else n_pass++;
    cycle(1, 1, 1, 2'd1);
    n_total++;
    if (obs_a !== RST_OBS) $display("FAIL mid_reset: got %h expected %h", obs_a, RST_OBS);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit early_done = 1'b0;
    cycle(1, 1, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 2'd3);
      if (i < 3) early_done |= b_ed;
    end
    n_total++;
    if (early_done) $display("FAIL timeout_early_done: got 1 expected 0");
    else n_pass++;
    n_total++;
    if ({b_st, b_rw, b_ed, b_sv, b_ec, b_sc, b_ready} !==
        {6'd0, 16'hFFF6, 1'b1, 1'b1, 16'd1, 8'd4, 1'b0})
      $display("FAIL timeout_step: got st=%0d rw=%h ed=%b sv=%b ec=%0d sc=%0d rdy=%b expected st=0 rw=fff6 ed=1 sv=1 ec=1 sc=4 rdy=0",
               b_st, b_rw, b_ed, b_sv, b_ec, b_sc, b_ready);
    else n_pass++;
    cycle(0, 0, 1, 2'd1);
    cycle(0, 0, 1, 2'd1);
    n_total++;
    if ({b_ready, b_sv, b_ed, b_sc} !== {1'b0, 1'b0, 1'b0, 8'd4})
      $display("FAIL restart_hold: got rdy=%b sv=%b ed=%b sc=%0d expected rdy=0 sv=0 ed=0 sc=4",
               b_ready, b_sv, b_ed, b_sc);
    else n_pass++;
    cycle(0, 1, 0, 2'd0);
    n_total++;
    if ({b_st, b_sc, b_sv, b_ready, b_ec} !== {6'd0, 8'd0, 1'b1, 1'b1, 16'd1})
      $display("FAIL timeout_restart: got st=%0d sc=%0d sv=%b rdy=%b ec=%0d expected st=0 sc=0 sv=1 rdy=1 ec=1",
               b_st, b_sc, b_sv, b_ready, b_ec);
    else n_pass++;
  endtask

  task automatic test_enable();
    obs_t want;
    cycle(1, 1, 0, 2'd0);
    cycle(0, 1, 1, 2'd1);
    want = {1'b1, 6'd1, 16'hFFFF, 1'b0, 1'b0, 8'd1, 16'd0};
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 2'($urandom_range(3)));
      n_total++;
      if (obs_a !== want) $display("FAIL enable_freeze[%0d]: got %h expected %h", i, obs_a, want);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit         r, e, v;
    logic [1:0] a;
    cycle(1, 1, 0, 2'd0);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(199) == 0);
      e = ($urandom_range(7) != 0);
      v = ($urandom_range(3) != 0);
      a = ($urandom_range(9) < 6) ? ($urandom_range(1) == 0 ? 2'd1 : 2'd2) : 2'($urandom_range(3));
      cycle(r, e, v, a);
      n_total++;
      if (obs_a !== exp_a) $display("FAIL random_a[%0d]: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
      n_total++;
      if (obs_b !== exp_b) $display("FAIL random_b[%0d]: got %h expected %h", i, obs_b, exp_b);
      else n_pass++;
    end
  endtask

  initial begin
    exp_a = RST_OBS;
    exp_b = RST_OBS;
    test_reset();
    test_single_right();
    test_wall();
    test_obstacle();
    test_goal();
    test_reset_mid();
    test_timeout();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
